// File: rtl/conv_pkg.sv
// Shared types and constants for the conv engine layer-memory path.
package conv_pkg;

  localparam int unsigned CONV_AW = 12;
  localparam int unsigned CONV_DW = 20;
  localparam int unsigned CSEL_W  = 3;

  typedef enum logic [CSEL_W-1:0] {
    CSEL_NONE  = 3'd0,
    CSEL_L0_K0 = 3'd1,
    CSEL_L0_K1 = 3'd2,
    CSEL_L1_K0 = 3'd3,
    CSEL_L1_K1 = 3'd4,
    CSEL_L2    = 3'd5
  } csel_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_mem_arbiter_if.sv
// Requester side and layer-memory side signals of the conv memory arbiter.
interface conv_mem_arbiter_if
  import conv_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = CONV_AW,
  parameter int unsigned DW   = CONV_DW
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [NREQ-1:0]        req_last;
  logic [CSEL_W*NREQ-1:0] req_sel;
  logic [AW*NREQ-1:0]     req_addr;
  logic [DW*NREQ-1:0]     req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rd_valid;
  logic [DW-1:0]          rd_data;
  logic                   busy;

  logic                   cwr;
  logic                   crd;
  logic [AW-1:0]          caddr_wr;
  logic [AW-1:0]          caddr_rd;
  logic [DW-1:0]          cdata_wr;
  logic [DW-1:0]          cdata_rd;
  logic [CSEL_W-1:0]      csel;

  modport master (
    output req_valid, req_we, req_last, req_sel, req_addr, req_wdata, cdata_rd,
    input  gnt, rd_valid, rd_data, busy, cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel
  );

  modport slave (
    input  req_valid, req_we, req_last, req_sel, req_addr, req_wdata, cdata_rd,
    output gnt, rd_valid, rd_data, busy, cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx,
  output logic            any_valid
);

  always_comb begin
    logic [PW-1:0] j;
    j         = '0;
    pick      = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      j = PW'((32'(ptr) + off) % NREQ);
      if (!any_valid && valid[j]) begin
        any_valid = 1'b1;
        pick[j]   = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/conv_mem_arbiter.sv
// Round-robin, burst-locking arbiter for the conv engine's single layer-memory port.
// Optional ARB_STATS_EN adds per-requester saturating wait counters on stat_wait.
module conv_mem_arbiter
  import conv_pkg::*;
#(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned AW        = CONV_AW,
  parameter int unsigned DW        = CONV_DW,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  conv_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0] stat_wait
`endif
);

  localparam int unsigned PW = idx_w(NREQ);
  localparam int unsigned BW = 4;
  localparam int unsigned SW = CSEL_W;

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic [NREQ-1:0] owner_oh_q, owner_oh_d, pick, gnt_c;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            any_valid, owner_valid, accept, acc_we, acc_last;
  logic [SW-1:0]   acc_sel;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_wdata;

  logic            cwr_q, crd_q;
  logic [SW-1:0]   csel_q;
  logic [AW-1:0]   caddr_wr_q, caddr_rd_q;
  logic [DW-1:0]   cdata_wr_q, rd_data_q;
  logic [NREQ-1:0] cmd_owner_q, rd_valid_q;

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
    .valid     (bus.req_valid),
    .ptr       (rr_ptr_q),
    .pick      (pick),
    .idx       (pick_idx),
    .any_valid (any_valid)
  );

  // Current owner's beat fields.
  always_comb begin
    owner_valid = 1'b0;
    acc_we      = 1'b0;
    acc_last    = 1'b0;
    acc_sel     = '0;
    acc_addr    = '0;
    acc_wdata   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == PW'(i)) begin
        owner_valid = bus.req_valid[i];
        acc_we      = bus.req_we[i];
        acc_last    = bus.req_last[i];
        acc_sel     = bus.req_sel[i*SW +: SW];
        acc_addr    = bus.req_addr[i*AW +: AW];
        acc_wdata   = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  assign accept = (state_q == ARB_OWN) && owner_valid;
  assign gnt_c  = accept ? owner_oh_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // IDLE spends one cycle arbitrating; OWN holds the lock until last beat or burst cap.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          state_d    = ARB_OWN;
          owner_d    = pick_idx;
          owner_oh_d = pick;
          beat_cnt_d = '0;
        end
      end
      ARB_OWN: begin
        if (accept) begin
          if (acc_last || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
            state_d    = ARB_IDLE;
            rr_ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Memory command one cycle after accept; read return carries the owner tag of its beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwr_q       <= 1'b0;
      crd_q       <= 1'b0;
      csel_q      <= CSEL_NONE;
      caddr_wr_q  <= '0;
      caddr_rd_q  <= '0;
      cdata_wr_q  <= '0;
      cmd_owner_q <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      cwr_q       <= accept && acc_we;
      crd_q       <= accept && !acc_we;
      csel_q      <= accept ? acc_sel : CSEL_NONE;
      caddr_wr_q  <= (accept && acc_we)  ? acc_addr  : '0;
      caddr_rd_q  <= (accept && !acc_we) ? acc_addr  : '0;
      cdata_wr_q  <= (accept && acc_we)  ? acc_wdata : '0;
      cmd_owner_q <= accept ? owner_oh_q : '0;
      rd_valid_q  <= crd_q ? cmd_owner_q  : '0;
      rd_data_q   <= crd_q ? bus.cdata_rd : '0;
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = (state_q == ARB_OWN) || cwr_q || crd_q;
  assign bus.cwr      = cwr_q;
  assign bus.crd      = crd_q;
  assign bus.csel     = csel_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.cdata_wr = cdata_wr_q;

`ifdef ARB_STATS_EN
  logic [15:0] wait_q [NREQ];

  // Cycles each requester spends valid but ungranted, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREQ; i++) wait_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !gnt_c[i] && (wait_q[i] != 16'hFFFF))
          wait_q[i] <= wait_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_wait = '0;
    for (int unsigned i = 0; i < NREQ; i++) stat_wait[i*16 +: 16] = wait_q[i];
  end
`endif

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed bench for conv_mem_arbiter: arbitration order, bursts, reads, stalls, reset.
module tb_conv_mem_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 20;

  logic clk = 1'b0;
  logic reset;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  conv_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [16*NREQ-1:0] stat_wait;
`endif

  conv_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_wait (stat_wait)
`endif
  );

  logic [NREQ-1:0] v, we, last;
  logic [2:0]      sel  [NREQ];
  logic [AW-1:0]   addr [NREQ];
  logic [DW-1:0]   data [NREQ];

  always_comb begin
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_last  = last;
    bus.req_sel   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_sel[i*3 +: 3]    = sel[i];
      bus.req_addr[i*AW +: AW] = addr[i];
      bus.req_wdata[i*DW +: DW] = data[i];
    end
  end

  // Memory model: one known word at 0x3FF, otherwise an address-derived pattern.
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return (a == 12'h3FF) ? 20'hABCDE : {8'h5A, a};
  endfunction

  assign bus.cdata_rd = bus.crd ? mem_rd(bus.caddr_rd) : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] i, input logic vv, input logic w, input logic l,
                         input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    v[i]    = vv;
    we[i]   = w;
    last[i] = l;
    sel[i]  = s;
    addr[i] = a;
    data[i] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NREQ; i++) set_req(2'(i), 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    idle_all();
    for (int i = 0; i < NREQ; i++)
      set_req(2'(i), 1'b1, 1'b1, 1'b1, 3'(i + 1), 12'(i), 20'(i));

    // Reset held with all requesters valid
    repeat (2) nxt();
    #1;
    chk("rst_gnt",      32'(bus.gnt),      32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_cwr",      32'(bus.cwr),      32'h0);
    chk("rst_crd",      32'(bus.crd),      32'h0);
    chk("rst_csel",     32'(bus.csel),     32'h0);
    chk("rst_caddr_wr", 32'(bus.caddr_wr), 32'h0);
    chk("rst_caddr_rd", 32'(bus.caddr_rd), 32'h0);
    chk("rst_cdata_wr", 32'(bus.cdata_wr), 32'h0);
    chk("rst_rd_data",  32'(bus.rd_data),  32'h0);
    chk("rst_busy",     32'(bus.busy),     32'h0);

    // Test 1: grant order 0,1,2,0 with single-beat bursts
    nxt(); reset = 1'b1; #1;
    chk("t1_bubble", 32'(bus.gnt), 32'h0);
    for (int k = 0; k < 4; k++) begin
      nxt(); #1;
      chk("t1_gnt", 32'(bus.gnt), 32'(1 << (k % 3)));
      nxt();
      if (k == 3) idle_all();
      #1;
      chk("t1_gap",   32'(bus.gnt),      32'h0);
      chk("t1_cwr",   32'(bus.cwr),      32'h1);
      chk("t1_csel",  32'(bus.csel),     32'((k % 3) + 1));
      chk("t1_addr",  32'(bus.caddr_wr), 32'(k % 3));
      chk("t1_wdata", 32'(bus.cdata_wr), 32'(k % 3));
    end
    nxt(); #1;
    chk("t1_end_cwr",  32'(bus.cwr),  32'h0);
    chk("t1_end_busy", 32'(bus.busy), 32'h0);

    // Test 2: req0 four-beat write burst
    nxt(); set_req(2'd0, 1'b1, 1'b1, 1'b0, 3'd1, 12'h000, 20'h12345); #1;
    chk("t2_bubble", 32'(bus.gnt), 32'h0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      set_req(2'd0, 1'b1, 1'b1, (k == 3), 3'd1, 12'(k), 20'(20'h12345 + k));
      #1;
      chk("t2_gnt", 32'(bus.gnt), 32'h1);
      if (k > 0) begin
        chk("t2_cwr",   32'(bus.cwr),      32'h1);
        chk("t2_csel",  32'(bus.csel),     32'h1);
        chk("t2_addr",  32'(bus.caddr_wr), 32'(k - 1));
        chk("t2_wdata", 32'(bus.cdata_wr), 32'(20'h12345 + k - 1));
      end
    end
    nxt(); idle_all(); #1;
    chk("t2_rel_gnt", 32'(bus.gnt),      32'h0);
    chk("t2_cwr4",    32'(bus.cwr),      32'h1);
    chk("t2_addr4",   32'(bus.caddr_wr), 32'h3);
    chk("t2_wdata4",  32'(bus.cdata_wr), 32'h12348);
    chk("t2_busy",    32'(bus.busy),     32'h1);
    nxt(); #1;
    chk("t2_idle_cwr",  32'(bus.cwr),      32'h0);
    chk("t2_idle_csel", 32'(bus.csel),     32'h0);
    chk("t2_idle_addr", 32'(bus.caddr_wr), 32'h0);
    chk("t2_idle_busy", 32'(bus.busy),     32'h0);

    // Test 3: req1 single read of 0x3FF
    nxt(); set_req(2'd1, 1'b1, 1'b0, 1'b1, 3'd3, 12'h3FF, 20'h0); #1;
    chk("t3_bubble", 32'(bus.gnt), 32'h0);
    nxt(); #1;
    chk("t3_gnt", 32'(bus.gnt), 32'h2);
    nxt(); idle_all(); #1;
    chk("t3_crd",      32'(bus.crd),      32'h1);
    chk("t3_cwr",      32'(bus.cwr),      32'h0);
    chk("t3_raddr",    32'(bus.caddr_rd), 32'h3FF);
    chk("t3_waddr",    32'(bus.caddr_wr), 32'h0);
    chk("t3_csel",     32'(bus.csel),     32'h3);
    chk("t3_rv_early", 32'(bus.rd_valid), 32'h0);
    chk("t3_busy",     32'(bus.busy),     32'h1);
    nxt(); #1;
    chk("t3_crd_off",   32'(bus.crd),      32'h0);
    chk("t3_rd_valid",  32'(bus.rd_valid), 32'h2);
    chk("t3_rd_data",   32'(bus.rd_data),  32'hABCDE);
    nxt(); #1;
    chk("t3_rv_done",   32'(bus.rd_valid), 32'h0);

    // Test 4: req2 capped at 4 beats, req0 (csel 7) served, req2 resumes
    nxt();
    set_req(2'd2, 1'b1, 1'b1, 1'b0, 3'd5, 12'h100, 20'h00100);
    set_req(2'd0, 1'b1, 1'b1, 1'b1, 3'd7, 12'h050, 20'h00050);
    #1;
    chk("t4_bubble", 32'(bus.gnt), 32'h0);
    for (int b = 0; b < 4; b++) begin
      nxt(); set_req(2'd2, 1'b1, 1'b1, 1'b0, 3'd5, 12'(12'h100 + b), 20'(20'h100 + b)); #1;
      chk("t4_gnt2", 32'(bus.gnt), 32'h4);
    end
    nxt(); set_req(2'd2, 1'b1, 1'b1, 1'b0, 3'd5, 12'h104, 20'h00104); #1;
    chk("t4_cap_rel", 32'(bus.gnt),      32'h0);
    chk("t4_addr3",   32'(bus.caddr_wr), 32'h103);
    nxt(); #1;
    chk("t4_gnt0", 32'(bus.gnt), 32'h1);
    nxt(); v[0] = 1'b0; #1;
    chk("t4_gap",   32'(bus.gnt),      32'h0);
    chk("t4_addr0", 32'(bus.caddr_wr), 32'h050);
    chk("t4_csel7", 32'(bus.csel),     32'h7);
    nxt(); #1;
    chk("t4_resume", 32'(bus.gnt), 32'h4);
    nxt(); set_req(2'd2, 1'b1, 1'b1, 1'b1, 3'd5, 12'h105, 20'h00105); #1;
    chk("t4_gnt_last", 32'(bus.gnt),      32'h4);
    chk("t4_addr4",    32'(bus.caddr_wr), 32'h104);
    chk("t4_csel5",    32'(bus.csel),     32'h5);
    nxt(); idle_all(); #1;
    chk("t4_end_gnt", 32'(bus.gnt),      32'h0);
    chk("t4_addr5",   32'(bus.caddr_wr), 32'h105);

    // Test 5: owner stalls 3 cycles while req1 waits
    nxt();
    set_req(2'd0, 1'b1, 1'b1, 1'b0, 3'd1, 12'h200, 20'h00200);
    set_req(2'd1, 1'b1, 1'b1, 1'b1, 3'd2, 12'h300, 20'h00300);
    #1;
    chk("t5_bubble", 32'(bus.gnt), 32'h0);
    nxt(); #1;
    chk("t5_gnt_b0", 32'(bus.gnt), 32'h1);
    for (int s = 0; s < 3; s++) begin
      nxt(); v[0] = 1'b0; #1;
      chk("t5_stall_gnt",  32'(bus.gnt),  32'h0);
      chk("t5_stall_busy", 32'(bus.busy), 32'h1);
      chk("t5_stall_cwr",  32'(bus.cwr),  (s == 0) ? 32'h1 : 32'h0);
    end
    nxt(); set_req(2'd0, 1'b1, 1'b1, 1'b0, 3'd1, 12'h201, 20'h00201); #1;
    chk("t5_gnt_b1", 32'(bus.gnt), 32'h1);
    nxt(); set_req(2'd0, 1'b1, 1'b1, 1'b1, 3'd1, 12'h202, 20'h00202); #1;
    chk("t5_gnt_b2", 32'(bus.gnt),      32'h1);
    chk("t5_addr1",  32'(bus.caddr_wr), 32'h201);
    nxt(); v[0] = 1'b0; #1;
    chk("t5_rel_gnt", 32'(bus.gnt),      32'h0);
    chk("t5_addr2",   32'(bus.caddr_wr), 32'h202);
    nxt(); #1;
    chk("t5_gnt1", 32'(bus.gnt), 32'h2);
    nxt(); idle_all(); #1;
    chk("t5_addr_r1", 32'(bus.caddr_wr), 32'h300);
    chk("t5_csel_r1", 32'(bus.csel),     32'h2);

    // Reset pulse mid-burst with a read in flight
    nxt(); set_req(2'd0, 1'b1, 1'b0, 1'b0, 3'd1, 12'h0AA, 20'h0); #1;
    chk("tr_bubble", 32'(bus.gnt), 32'h0);
    nxt(); #1;
    chk("tr_gnt", 32'(bus.gnt), 32'h1);
    nxt(); #1;
    chk("tr_crd_pre", 32'(bus.crd), 32'h1);
    #1; reset = 1'b0; #1;
    chk("tr_crd",    32'(bus.crd),      32'h0);
    chk("tr_raddr",  32'(bus.caddr_rd), 32'h0);
    chk("tr_csel",   32'(bus.csel),     32'h0);
    chk("tr_gnt0",   32'(bus.gnt),      32'h0);
    chk("tr_busy",   32'(bus.busy),     32'h0);
    chk("tr_rv",     32'(bus.rd_valid), 32'h0);
`ifdef ARB_STATS_EN
    chk("tr_stat", 32'(stat_wait[31:0]), 32'h0);
`endif
    idle_all();
    nxt(); reset = 1'b1;
    nxt(); #1;
    chk("tr_rv_discard", 32'(bus.rd_valid), 32'h0);
    chk("tr_rd_data",    32'(bus.rd_data),  32'h0);

`ifdef ARB_STATS_EN
    // Stats: req1 waits through IDLE, a 3-beat req0 burst and the next bubble
    nxt();
    set_req(2'd0, 1'b1, 1'b1, 1'b0, 3'd1, 12'h400, 20'h0);
    set_req(2'd1, 1'b1, 1'b1, 1'b1, 3'd2, 12'h500, 20'h0);
    #1;
    chk("ts_bubble", 32'(bus.gnt), 32'h0);
    for (int k = 0; k < 3; k++) begin
      nxt(); set_req(2'd0, 1'b1, 1'b1, (k == 2), 3'd1, 12'(12'h400 + k), 20'(k)); #1;
      chk("ts_gnt0", 32'(bus.gnt), 32'h1);
    end
    nxt(); v[0] = 1'b0; #1;
    chk("ts_gap", 32'(bus.gnt), 32'h0);
    nxt(); #1;
    chk("ts_gnt1", 32'(bus.gnt), 32'h2);
    nxt(); idle_all(); #1;
    chk("ts_wait1", 32'(stat_wait[31:16]), 32'd5);
    chk("ts_wait0", 32'(stat_wait[15:0]),  32'd1);
    chk("ts_wait2", 32'(stat_wait[47:32]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
